robots_scan_engine: RTL and testbench



---
 rtl/robots_scan_if.sv | 39 +++
 rtl/robots_scan_engine.sv | 146 ++++++++++++++
 tb/tb_robots_scan_engine.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/robots_scan_if.sv
// robots_scan_if: start/config, pacing and scan
// outputs between a controller and the scan engine.
interface robots_scan_if #(
  parameter int XBITS  = 7,
  parameter int YBITS  = 6,
  parameter int PHBITS = 3,
  parameter int OPBITS = 4
);
  logic                   start;
  logic [OPBITS-1:0]      start_op;
  logic                   start_fwd;
  logic                   start_vsync;
  logic                   start_pace;
  logic                   vblank;
  logic                   pace_rdy;
  logic                   hold;
  logic                   abort;
  logic                   busy;
  logic [OPBITS-1:0]      op;
  logic [XBITS-1:0]       x;
  logic [YBITS-1:0]       y;
  logic [PHBITS-1:0]      ph;
  logic [XBITS+YBITS-1:0] adr;
  logic                   run;
  logic                   done;
  logic                   aborted;

  modport master (
    output start, start_op, start_fwd, start_vsync,
    output start_pace, vblank, pace_rdy, hold, abort,
    input  busy, op, x, y, ph, adr, run, done, aborted
  );

  modport slave (
    input  start, start_op, start_fwd, start_vsync,
    input  start_pace, vblank, pace_rdy, hold, abort,
    output busy, op, x, y, ph, adr, run, done, aborted
  );
endinterface

// File: rtl/robots_scan_engine.sv
// robots_scan_engine: sweeps the tile grid cell by cell,
// spending PHASES cycles per cell, with vsync/pace/hold/abort.
module robots_scan_engine #(
  parameter int XBITS  = 7,
  parameter int YBITS  = 6,
  parameter int XMAX   = 127,
  parameter int YMAX   = 47,
  parameter int PHBITS = 3,
  parameter int PHASES = 5,
  parameter int OPBITS = 4
) (
  input logic        clk,
  input logic        rst,
  robots_scan_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, VWAIT, PACE, RUN
  } state_t;

  localparam logic [XBITS-1:0]  XM = XBITS'(XMAX);
  localparam logic [YBITS-1:0]  YM = YBITS'(YMAX);
  localparam logic [PHBITS-1:0] PL = PHBITS'(PHASES - 1);

  state_t            st_q, st_d;
  logic [XBITS-1:0]  x_q, x_d;
  logic [YBITS-1:0]  y_q, y_d;
  logic [PHBITS-1:0] ph_q, ph_d;
  logic [OPBITS-1:0] op_q, op_d;
  logic              done_q, done_d;
  logic              ab_q, ab_d;
  logic              fwd_q, fwd_d;
  logic              vs_q, vs_d;
  logic              pc_q, pc_d;
  logic              vb_q;
  logic              last;

  assign last = fwd_q ? (x_q == XM && y_q == YM)
                      : (x_q == '0 && y_q == '0);

  // State and datapath registers; vblank history resets high
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      ph_q   <= '0;
      op_q   <= '0;
      done_q <= 1'b0;
      ab_q   <= 1'b0;
      fwd_q  <= 1'b0;
      vs_q   <= 1'b0;
      pc_q   <= 1'b0;
      vb_q   <= 1'b1;
    end else begin
      st_q   <= st_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ph_q   <= ph_d;
      op_q   <= op_d;
      done_q <= done_d;
      ab_q   <= ab_d;
      fwd_q  <= fwd_d;
      vs_q   <= vs_d;
      pc_q   <= pc_d;
      vb_q   <= bus.vblank;
    end
  end

  // Next state: abort beats hold, hold beats stepping
  always_comb begin
    st_d   = st_q;
    x_d    = x_q;
    y_d    = y_q;
    ph_d   = ph_q;
    op_d   = op_q;
    done_d = 1'b0;
    ab_d   = 1'b0;
    fwd_d  = fwd_q;
    vs_d   = vs_q;
    pc_d   = pc_q;
    if (st_q == IDLE) begin
      if (bus.start) begin
        op_d  = bus.start_op;
        fwd_d = bus.start_fwd;
        vs_d  = bus.start_vsync;
        pc_d  = bus.start_pace;
        x_d   = bus.start_fwd ? '0 : XM;
        y_d   = bus.start_fwd ? '0 : YM;
        ph_d  = '0;
        st_d  = bus.start_vsync ? VWAIT : RUN;
      end
    end else if (bus.abort) begin
      st_d   = IDLE;
      done_d = 1'b1;
      ab_d   = 1'b1;
      ph_d   = '0;
    end else begin
      case (st_q)
        VWAIT:
          if (bus.vblank && !vb_q) st_d = RUN;
        PACE:
          if (bus.pace_rdy) st_d = RUN;
        RUN:
          if (!bus.hold) begin
            if (ph_q != PL) begin
              ph_d = ph_q + 1'b1;
            end else if (last) begin
              st_d   = IDLE;
              done_d = 1'b1;
              ph_d   = '0;
            end else begin
              ph_d = '0;
              st_d = pc_q ? PACE : RUN;
              unique case (1'b1)
                fwd_q:
                  if (x_q != XM) begin
                    x_d = x_q + 1'b1;
                  end else begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                  end
                !fwd_q:
                  if (x_q != '0) begin
                    x_d = x_q - 1'b1;
                  end else begin
                    x_d = XM;
                    y_d = y_q - 1'b1;
                  end
              endcase
            end
          end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (st_q != IDLE);
  assign bus.run     = (st_q == RUN);
  assign bus.op      = op_q;
  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.ph      = ph_q;
  assign bus.adr     = {y_q, x_q};
  assign bus.done    = done_q;
  assign bus.aborted = ab_q;
endmodule

// File: tb/tb_robots_scan_engine.sv
// tb_robots_scan_engine: directed scans on a 4x3 grid with
// a linear-index reference model checked every cycle.
module tb_robots_scan_engine;
  localparam int NX = 4;
  localparam int NY = 3;
  localparam int NC = NX * NY;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  robots_scan_if #(
    .XBITS(2), .YBITS(2), .PHBITS(3), .OPBITS(4)
  ) bus ();

  robots_scan_engine #(
    .XBITS(2), .YBITS(2), .XMAX(3), .YMAX(2),
    .PHBITS(3), .PHASES(NP), .OPBITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 vwait, 2 pace, 3 run.
  // Position is a raster index 0..NC-1 plus a phase.
  int m_mode, m_lin, m_ph, m_op;
  bit m_done, m_ab, m_fwd, m_vs, m_pc, m_vbp;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_lin = 0; m_ph = 0; m_op = 0;
      m_done = 0; m_ab = 0; m_vbp = 1;
    end else begin
      m_done = 0;
      m_ab = 0;
      if (m_mode == 0) begin
        if (bus.start) begin
          m_op  = int'(bus.start_op);
          m_fwd = bus.start_fwd;
          m_vs  = bus.start_vsync;
          m_pc  = bus.start_pace;
          m_lin = m_fwd ? 0 : NC - 1;
          m_ph  = 0;
          m_mode = m_vs ? 1 : 3;
        end
      end else if (bus.abort) begin
        m_mode = 0; m_done = 1; m_ab = 1; m_ph = 0;
      end else if (m_mode == 1) begin
        if (bus.vblank && !m_vbp) m_mode = 3;
      end else if (m_mode == 2) begin
        if (bus.pace_rdy) m_mode = 3;
      end else if (!bus.hold) begin
        if (m_ph < NP - 1) m_ph++;
        else if (m_lin == (m_fwd ? NC - 1 : 0)) begin
          m_mode = 0; m_done = 1; m_ph = 0;
        end else begin
          m_lin += m_fwd ? 1 : -1;
          m_ph = 0;
          m_mode = m_pc ? 2 : 3;
        end
      end
      m_vbp = bus.vblank;
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", bus.busy, m_mode != 0);
      chk("run", bus.run, m_mode == 3);
      chk("x", bus.x, m_lin % NX);
      chk("y", bus.y, m_lin / NX);
      chk("ph", bus.ph, m_ph);
      chk("op", bus.op, m_op);
      chk("done", bus.done, m_done);
      chk("aborted", bus.aborted, m_ab);
      chk("adr", bus.adr, (m_lin / NX) * 4 + m_lin % NX);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input logic [3:0] o, input bit f,
                    input bit v, input bit p);
    bus.start = 1'b1;
    bus.start_op = o;
    bus.start_fwd = f;
    bus.start_vsync = v;
    bus.start_pace = p;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 200) begin
      tick();
      n++;
    end
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got 0 want 1");
    end
  endtask

  int seq[24];
  int n;

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.start_op = 0; bus.start_fwd = 0;
    bus.start_vsync = 0; bus.start_pace = 0;
    bus.vblank = 0; bus.pace_rdy = 0;
    bus.hold = 0; bus.abort = 0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_adr", bus.adr, 0);
    chk("rst_done", bus.done, 0);

    // reverse scan, op 5
    go(4'd5, 0, 0, 0);
    chk("t1_first", bus.adr, 11);
    for (int i = 0; i < 24; i++) begin
      seq[i] = int'(bus.adr);
      tick();
    end
    chk("t1_seq1", seq[1], 11);
    chk("t1_seq2", seq[2], 10);
    chk("t1_seq21", seq[21], 1);
    chk("t1_seq23", seq[23], 0);
    chk("t1_done", bus.done, 1);
    chk("t1_abort", bus.aborted, 0);
    chk("t1_op", bus.op, 5);

    // forward scan started in the done cycle
    go(4'd2, 1, 0, 0);
    chk("t2_busy", bus.busy, 1);
    chk("t2_adr", bus.adr, 0);
    chk("t2_op", bus.op, 2);
    wait_done(n);
    chk("t2_len", n, 24);

    // hold at (2,1) ph1 for 3 cycles, back-to-back
    go(4'd6, 1, 0, 0);
    repeat (13) tick();
    chk("t3_x", bus.x, 2);
    chk("t3_y", bus.y, 1);
    chk("t3_ph", bus.ph, 1);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold", {bus.x, bus.y, bus.ph}, {2'd2, 2'd1, 3'd1});
    end
    bus.hold = 1'b0;
    wait_done(n);
    chk("t3_len", 16 + n, 27);

    // reverse pace scan, consumer stalls after cell 11
    tick();
    go(4'd7, 0, 0, 1);
    chk("t4_first", bus.adr, 11);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_pace", {bus.run, bus.x, bus.y}, {1'b0, 2'd2, 2'd2});
      if (i < 3) tick();
    end
    bus.pace_rdy = 1'b1;
    tick();
    chk("t4_resume", {bus.run, bus.adr}, {1'b1, 4'd10});
    wait_done(n);
    chk("t4_len", n, 32);
    bus.pace_rdy = 1'b0;

    // abort in idle is ignored
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("idle_abort", {bus.busy, bus.done}, 2'b00);

    // vsync start with vblank already high
    bus.vblank = 1'b1;
    tick();
    go(4'd3, 1, 1, 0);
    chk("t5_wait", {bus.busy, bus.run}, 2'b10);
    repeat (2) tick();
    chk("t5_hi", bus.run, 0);
    bus.vblank = 1'b0;
    repeat (2) tick();
    chk("t5_lo", bus.run, 0);
    bus.vblank = 1'b1;
    tick();
    chk("t5_run", {bus.run, bus.adr}, {1'b1, 4'd0});
    repeat (5) tick();
    bus.start = 1'b1;
    bus.start_op = 4'd9;
    bus.start_fwd = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("t5_busy_start", bus.op, 3);
    repeat (8) tick();
    chk("t5_cell7", {bus.x, bus.y}, {2'd3, 2'd1});
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5_abort", {bus.done, bus.aborted, bus.busy}, 3'b110);
    chk("t5_hold_xy", {bus.x, bus.y, bus.ph}, {2'd3, 2'd1, 3'd0});
    tick();
    chk("t5_pulse", bus.done, 0);

    // reset mid-scan
    go(4'd4, 1, 0, 0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst", {bus.busy, bus.done, bus.x, bus.y},
        {1'b0, 1'b0, 2'd0, 2'd0});
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
